// File: rtl/seg7_pattern_reader.sv
// Seven-segment readback: synchronizes an active-low segment pattern,
// waits for it to settle, then decodes it to a hex digit.
module seg7_pattern_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [6:0] SEG,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       is_blank,
  output logic       pattern_err,
  output logic       settled
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic {
    HOLD,
    SETTLE
  } state_t;

  state_t        state, state_n;
  logic [6:0]    seg_s1, seg_s2;
  logic [6:0]    prev, prev_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    digit_n;
  logic          valid_n, blank_n, err_n;
  logic [3:0]    dec_val;
  logic          dec_ok;

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (prev)
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // A change on seg_s2 always wins and restarts the settle count.
  always_comb begin
    state_n = state;
    prev_n  = prev;
    cnt_n   = cnt;
    digit_n = digit;
    valid_n = 1'b0;
    blank_n = is_blank;
    err_n   = pattern_err;
    if (seg_s2 != prev) begin
      prev_n  = seg_s2;
      cnt_n   = CW'(1);
      state_n = SETTLE;
    end else if (state == SETTLE) begin
      if (cnt < CMAX) begin
        cnt_n = cnt + CW'(1);
      end else begin
        state_n = HOLD;
        if (dec_ok) begin
          digit_n = dec_val;
          valid_n = 1'b1;
          blank_n = 1'b0;
          err_n   = 1'b0;
        end else if (prev == BLANK) begin
          blank_n = 1'b1;
          err_n   = 1'b0;
        end else begin
          blank_n = 1'b0;
          err_n   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      seg_s1      <= BLANK;
      seg_s2      <= BLANK;
      prev        <= BLANK;
      cnt         <= '0;
      state       <= HOLD;
      digit       <= 4'h0;
      digit_valid <= 1'b0;
      is_blank    <= 1'b1;
      pattern_err <= 1'b0;
    end else begin
      seg_s1      <= SEG;
      seg_s2      <= seg_s1;
      prev        <= prev_n;
      cnt         <= cnt_n;
      state       <= state_n;
      digit       <= digit_n;
      digit_valid <= valid_n;
      is_blank    <= blank_n;
      pattern_err <= err_n;
    end
  end

  assign settled = (state == HOLD);

endmodule

// File: tb/tb_seg7_pattern_reader.sv
// Bench for seg7_pattern_reader: default and single-cycle settle
// instances against a run-length model of the sampled pattern.
module tb_seg7_pattern_reader;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [6:0] seg  = 7'h7F;

  logic [3:0] o_digit[2];
  logic       o_valid[2], o_blank[2], o_err[2], o_set[2];

  int checks = 0;
  int errors = 0;

  int         sc[2] = '{4, 1};
  logic [6:0] codes[16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                            7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03,
                            7'h46, 7'h21, 7'h06, 7'h0E};

  // Every pattern captured since reset; the front is padded with the
  // blank pattern the synchronizer holds during reset.
  logic [6:0] hist[$];
  logic [3:0] m_digit[2];
  logic       m_valid[2], m_blank[2], m_err[2], m_set[2];

  always #5 clk = ~clk;

  seg7_pattern_reader #(.STABLE_CYCLES(4)) dut0 (
    .CLOCK_50    (clk),
    .Resetn      (rstn),
    .SEG         (seg),
    .digit       (o_digit[0]),
    .digit_valid (o_valid[0]),
    .is_blank    (o_blank[0]),
    .pattern_err (o_err[0]),
    .settled     (o_set[0])
  );

  seg7_pattern_reader #(.STABLE_CYCLES(1)) dut1 (
    .CLOCK_50    (clk),
    .Resetn      (rstn),
    .SEG         (seg),
    .digit       (o_digit[1]),
    .digit_valid (o_valid[1]),
    .is_blank    (o_blank[1]),
    .pattern_err (o_err[1]),
    .settled     (o_set[1])
  );

  function automatic void model_reset();
    hist.delete();
    for (int j = 0; j < 8; j++) hist.push_back(7'h7F);
    for (int i = 0; i < 2; i++) begin
      m_digit[i] = 4'h0;
      m_valid[i] = 1'b0;
      m_blank[i] = 1'b1;
      m_err[i]   = 1'b0;
      m_set[i]   = 1'b1;
    end
  endfunction

  // The value seen downstream lags capture by two edges. A run of it that
  // began with a real change is accepted once it spans S+1 edges.
  function automatic void model_edge(input logic [6:0] v);
    int         l, r, idx;
    bit         bnd;
    logic [6:0] cur;
    hist.push_back(v);
    l   = hist.size() - 1;
    cur = hist[l-2];
    for (int i = 0; i < 2; i++) begin
      r   = 0;
      bnd = 1'b0;
      for (int j = 0; j <= sc[i] + 1; j++) begin
        if (hist[l-2-j] != cur) begin
          bnd = 1'b1;
          break;
        end
        r++;
      end
      m_set[i]   = !(bnd && r <= sc[i]);
      m_valid[i] = 1'b0;
      if (bnd && r == sc[i] + 1) begin
        idx = -1;
        for (int k = 0; k < 16; k++) if (codes[k] == cur) idx = k;
        if (idx >= 0) begin
          m_digit[i] = 4'(idx);
          m_valid[i] = 1'b1;
          m_blank[i] = 1'b0;
          m_err[i]   = 1'b0;
        end else if (cur == 7'h7F) begin
          m_blank[i] = 1'b1;
          m_err[i]   = 1'b0;
        end else begin
          m_blank[i] = 1'b0;
          m_err[i]   = 1'b1;
        end
      end
    end
  endfunction

  task automatic tick(input logic [6:0] s);
    @(negedge clk);
    seg = s;
    @(posedge clk);
    model_edge(s);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    seg  = 7'h7F;
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i]}
          !== {4'h0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL reset_vals dut%0d got d=%h v=%b b=%b e=%b s=%b want d=0 v=0 b=1 e=0 s=1",
                 i, o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i]);
      end
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick(7'h7F);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i]}
            !== {m_digit[i], m_valid[i], m_blank[i], m_err[i], m_set[i]}) begin
          errors++;
          $display("FAIL reset_idle dut%0d t=%0d got d=%h v=%b b=%b e=%b s=%b want d=%h v=%b b=%b e=%b s=%b",
                   i, t, o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i],
                   m_digit[i], m_valid[i], m_blank[i], m_err[i], m_set[i]);
        end
      end
    end
  endtask

  task automatic test_single();
    int pulses = 0;
    for (int t = 1; t <= 57; t++) begin
      tick(7'h24);
      pulses += int'(o_valid[0]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i]}
            !== {m_digit[i], m_valid[i], m_blank[i], m_err[i], m_set[i]}) begin
          errors++;
          $display("FAIL single dut%0d edge=%0d got d=%h v=%b b=%b e=%b s=%b want d=%h v=%b b=%b e=%b s=%b",
                   i, t, o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i],
                   m_digit[i], m_valid[i], m_blank[i], m_err[i], m_set[i]);
        end
      end
      if (t == 3 || t == 7) begin
        checks++;
        if (o_set[0] !== (t == 7) || o_valid[0] !== (t == 7)) begin
          errors++;
          $display("FAIL single_timing edge=%0d got s=%b v=%b want s=%b v=%b",
                   t, o_set[0], o_valid[0], t == 7, t == 7);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL single_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_glitch();
    logic [6:0] stim[$];
    int pulses = 0;
    repeat (3) stim.push_back(7'h79);
    stim.push_back(7'h7D);
    repeat (20) stim.push_back(7'h79);
    foreach (stim[n]) begin
      tick(stim[n]);
      pulses += int'(o_valid[0]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i]}
            !== {m_digit[i], m_valid[i], m_blank[i], m_err[i], m_set[i]}) begin
          errors++;
          $display("FAIL glitch dut%0d n=%0d got d=%h v=%b b=%b e=%b s=%b want d=%h v=%b b=%b e=%b s=%b",
                   i, n, o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i],
                   m_digit[i], m_valid[i], m_blank[i], m_err[i], m_set[i]);
        end
      end
    end
    checks++;
    if (pulses != 1 || o_digit[0] !== 4'h1) begin
      errors++;
      $display("FAIL glitch_once got pulses=%0d d=%h want pulses=1 d=1",
               pulses, o_digit[0]);
    end
  endtask

  task automatic test_error();
    logic [6:0] pats[3] = '{7'h0E, 7'h7E, 7'h46};
    for (int p = 0; p < 3; p++) begin
      for (int t = 0; t < 12; t++) begin
        tick(pats[p]);
        for (int i = 0; i < 2; i++) begin
          checks++;
          if ({o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i]}
              !== {m_digit[i], m_valid[i], m_blank[i], m_err[i], m_set[i]}) begin
            errors++;
            $display("FAIL error_seq dut%0d p=%0d t=%0d got d=%h v=%b b=%b e=%b s=%b want d=%h v=%b b=%b e=%b s=%b",
                     i, p, t, o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i],
                     m_digit[i], m_valid[i], m_blank[i], m_err[i], m_set[i]);
          end
        end
      end
      checks++;
      if (o_digit[0] !== (p == 2 ? 4'hC : 4'hF) || o_err[0] !== (p == 1)) begin
        errors++;
        $display("FAIL error_end p=%0d got d=%h e=%b want d=%h e=%b",
                 p, o_digit[0], o_err[0], p == 2 ? 4'hC : 4'hF, p == 1);
      end
    end
  endtask

  task automatic test_walk();
    int pulses = 0;
    for (int d = 0; d < 16; d++) begin
      for (int t = 0; t < 10; t++) begin
        tick(codes[d]);
        pulses += int'(o_valid[0]);
        for (int i = 0; i < 2; i++) begin
          checks++;
          if ({o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i]}
              !== {m_digit[i], m_valid[i], m_blank[i], m_err[i], m_set[i]}) begin
            errors++;
            $display("FAIL walk dut%0d d=%0d t=%0d got d=%h v=%b b=%b e=%b s=%b want d=%h v=%b b=%b e=%b s=%b",
                     i, d, t, o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i],
                     m_digit[i], m_valid[i], m_blank[i], m_err[i], m_set[i]);
          end
        end
      end
      checks++;
      if (o_digit[0] !== 4'(d) || o_err[0] !== 1'b0) begin
        errors++;
        $display("FAIL walk_digit got d=%h e=%b want d=%h e=0", o_digit[0], o_err[0], d);
      end
    end
    checks++;
    if (pulses != 16) begin
      errors++;
      $display("FAIL walk_pulses got %0d want 16", pulses);
    end
  endtask

  task automatic test_reset_settle();
    repeat (4) tick(7'h30);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i]}
          !== {4'h0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL async_reset dut%0d got d=%h v=%b b=%b e=%b s=%b want d=0 v=0 b=1 e=0 s=1",
                 i, o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i]);
      end
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick(7'h30);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i]}
            !== {m_digit[i], m_valid[i], m_blank[i], m_err[i], m_set[i]}) begin
          errors++;
          $display("FAIL post_reset dut%0d edge=%0d got d=%h v=%b b=%b e=%b s=%b want d=%h v=%b b=%b e=%b s=%b",
                   i, t, o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i],
                   m_digit[i], m_valid[i], m_blank[i], m_err[i], m_set[i]);
        end
      end
      if (t == 7) begin
        checks++;
        if (o_valid[0] !== 1'b1 || o_digit[0] !== 4'h3) begin
          errors++;
          $display("FAIL post_reset_accept got v=%b d=%h want v=1 d=3",
                   o_valid[0], o_digit[0]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] p;
    int         len;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    p = codes[$urandom_range(0, 15)];
        2:       p = 7'h7F;
        default: p = 7'($urandom);
      endcase
      len = $urandom_range(1, 8);
      for (int t = 0; t < len; t++) begin
        tick(p);
        for (int i = 0; i < 2; i++) begin
          checks++;
          if ({o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i]}
              !== {m_digit[i], m_valid[i], m_blank[i], m_err[i], m_set[i]}) begin
            errors++;
            $display("FAIL random dut%0d n=%0d pat=%h got d=%h v=%b b=%b e=%b s=%b want d=%h v=%b b=%b e=%b s=%b",
                     i, n, p, o_digit[i], o_valid[i], o_blank[i], o_err[i], o_set[i],
                     m_digit[i], m_valid[i], m_blank[i], m_err[i], m_set[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_error();
    test_walk();
    test_reset_settle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_pattern_reader.md
Name: seg7_pattern_reader

Overview:
- Reverse direction of the board's hex-digit display drive.
- Samples a 7-bit active-low seven-segment pattern, for example a HEX bus looped back or driven by a neighbouring board, and decodes it to a 4-bit hex value.
- Requires the pattern to be stable before accepting it, and flags blank and unrecognised patterns.
- Used as the self-check/readback stage behind any display encoder in the lab designs.

Parameters:
- STABLE_CYCLES, 4: consecutive synchronized clocks a pattern must hold before acceptance. Legal range 1..255.

Ports:
- CLOCK_50  input  1  system clock; all flops on rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- SEG  input  7  segment pattern, active-low. Bit 0 = a, bit 1 = b, …, bit 6 = g. Asynchronous to CLOCK_50.
- digit  output  4  last accepted hex value.
- digit_valid  output  1  one-cycle pulse when a legal digit is accepted.
- is_blank  output  1  level: last accepted pattern was all-off (7'h7F).
- pattern_err  output  1  level: last accepted pattern matched no legal code.
- settled  output  1  level: FSM is in HOLD.

Behaviour:
- Reset values:
  - Sync flops seg_s1 and seg_s2 = 7'h7F; prev = 7'h7F.
  - cnt = 0; state = HOLD.
  - digit = 0, digit_valid = 0, is_blank = 1, pattern_err = 0, settled = 1.
- Synchronizer: SEG → seg_s1 → seg_s2. Only seg_s2 is used downstream.
- Change detect, any state: if seg_s2 != prev → prev <= seg_s2, cnt <= 1, state <= SETTLE. Change overrides every other action on that edge.
- SETTLE, no change:
  - If cnt < STABLE_CYCLES → cnt <= cnt + 1.
  - If cnt == STABLE_CYCLES → accept: state <= HOLD, outputs update as below.
- HOLD, no change: no action. Outputs hold; digit_valid = 0. No repeated pulses for a steady pattern.
- Accept, decode on prev. Legal codes (bit order g..a, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Accept results:
  - Legal code: digit <= value, digit_valid <= 1 for exactly one cycle, is_blank <= 0, pattern_err <= 0.
  - 7F: is_blank <= 1, pattern_err <= 0, digit unchanged, no pulse.
  - Any other pattern: pattern_err <= 1, is_blank <= 0, digit unchanged, no pulse.
- settled = (state == HOLD), registered with state.
- Latency: call edge 1 the edge at which seg_s1 first captures a new SEG value.
  - prev updates and cnt = 1 on edge 3.
  - cnt reaches STABLE_CYCLES on edge STABLE_CYCLES + 2.
  - Accept on edge STABLE_CYCLES + 3, i.e. edge 7 for default 4.
  - digit_valid is high for the cycle after that edge.
- Glitches: any change of seg_s2 before acceptance restarts the count. A pattern that changes and returns to the previous value is re-accepted and pulses again.
- Arithmetic:
  - cnt width = ceil(log2(STABLE_CYCLES + 1)). cnt saturates; it never wraps.
  - STABLE_CYCLES = 1: acceptance on the edge after the change edge.
- Reset mid-SETTLE: everything returns to reset values immediately (asynchronous), and no pulse is issued.

Test Plan:
1. Reset, SEG held at 7'h7F, 20 cycles → digit=0, is_blank=1, settled=1, digit_valid never high.
2. SEG 7F→24 (STABLE_CYCLES=4) → settled drops after edge 3. digit=2 with digit_valid high only in the cycle after edge 7. No further pulse over 50 cycles.
3. SEG 79 with a single-cycle glitch to 7D at edge 4, then 79 again → count restarts at each change. Exactly one pulse (digit=1), 7 edges after the last change is sampled.
4. SEG 0E then 7E → first accept digit=F with a pulse. Second accept pattern_err=1, digit stays F, no pulse. Then SEG 46 → pattern_err=0, digit=C, one pulse.
5. Walk all 16 legal codes, each held 10 cycles → digit matches each value in order, 16 pulses total, pattern_err=0 throughout.
6. Resetn low during SETTLE at cnt=2 → outputs return to reset values asynchronously; no pulse. SEG kept at 30 after release → digit=3 accepted 7 edges after release.
